// File: rtl/hazard_ctrl_if.sv
// Pipeline-side bundle for hazard_ctrl: hazard inputs from the stage
// registers and the stall/flush/forward controls going back to them.
interface hazard_ctrl_if #(
   parameter int unsigned CNT_W = 32
);
   logic             trigger_i;
   logic             halt_i;
   logic             mem_busy_i;
   logic [4:0]       Rs1D_i;
   logic [4:0]       Rs2D_i;
   logic [4:0]       Rs1E_i;
   logic [4:0]       Rs2E_i;
   logic [4:0]       RdE_i;
   logic [4:0]       RdM_i;
   logic [4:0]       RdW_i;
   logic [1:0]       ResultSrcE_i;
   logic             RegWriteM_i;
   logic             RegWriteW_i;
   logic             PCSrcE_i;
   logic             StallF_o;
   logic             StallD_o;
   logic             StallE_o;
   logic             StallM_o;
   logic             FlushD_o;
   logic             FlushE_o;
   logic             FlushW_o;
   logic [1:0]       ForwardAE_o;
   logic [1:0]       ForwardBE_o;
   logic [1:0]       state_o;
   logic [CNT_W-1:0] stall_cnt_o;
   logic [CNT_W-1:0] flush_cnt_o;

   // Pipeline / datapath side
   modport master (
      output trigger_i, halt_i, mem_busy_i,
      output Rs1D_i, Rs2D_i, Rs1E_i, Rs2E_i, RdE_i, RdM_i, RdW_i,
      output ResultSrcE_i, RegWriteM_i, RegWriteW_i, PCSrcE_i,
      input  StallF_o, StallD_o, StallE_o, StallM_o,
      input  FlushD_o, FlushE_o, FlushW_o,
      input  ForwardAE_o, ForwardBE_o, state_o, stall_cnt_o, flush_cnt_o
   );

   // Hazard controller side
   modport slave (
      input  trigger_i, halt_i, mem_busy_i,
      input  Rs1D_i, Rs2D_i, Rs1E_i, Rs2E_i, RdE_i, RdM_i, RdW_i,
      input  ResultSrcE_i, RegWriteM_i, RegWriteW_i, PCSrcE_i,
      output StallF_o, StallD_o, StallE_o, StallM_o,
      output FlushD_o, FlushE_o, FlushW_o,
      output ForwardAE_o, ForwardBE_o, state_o, stall_cnt_o, flush_cnt_o
   );
endinterface

// File: rtl/hazard_ctrl.sv
// Hazard controller for the 5-stage RV32I pipeline: load-use and redirect
// hazards, E-stage forwarding, run/halt/drain lifecycle, memory-wait freeze
// and saturating stall/flush performance counters.
module hazard_ctrl #(
   parameter int unsigned CNT_W     = 32,
   parameter int unsigned DRAIN_CYC = 3
) (
   input logic          clk,
   input logic          rst,
   hazard_ctrl_if.slave bus
);

   localparam int unsigned DW = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;

   typedef enum logic [1:0] {
      S_IDLE  = 2'b00,
      S_RUN   = 2'b01,
      S_DRAIN = 2'b10
   } state_t;

   state_t           state_q, state_d;
   logic [DW-1:0]    drain_q, drain_d;
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
   logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

   logic stall_f, stall_d, stall_e, stall_m;
   logic flush_d, flush_e, flush_w;
   logic freeze, lw_stall, flush_inc;

   // Operand forwarding into E: the younger producer in M wins over W
   always_comb begin
      bus.ForwardAE_o = 2'b00;
      bus.ForwardBE_o = 2'b00;
      if (bus.RegWriteM_i && bus.RdM_i != 5'd0 && bus.RdM_i == bus.Rs1E_i)
         bus.ForwardAE_o = 2'b10;
      else if (bus.RegWriteW_i && bus.RdW_i != 5'd0 && bus.RdW_i == bus.Rs1E_i)
         bus.ForwardAE_o = 2'b01;
      if (bus.RegWriteM_i && bus.RdM_i != 5'd0 && bus.RdM_i == bus.Rs2E_i)
         bus.ForwardBE_o = 2'b10;
      else if (bus.RegWriteW_i && bus.RdW_i != 5'd0 && bus.RdW_i == bus.Rs2E_i)
         bus.ForwardBE_o = 2'b01;
   end

   // Stall/flush decode, lifecycle next state and counter updates
   always_comb begin
      state_d     = state_q;
      drain_d     = drain_q;
      stall_cnt_d = stall_cnt_q;
      flush_cnt_d = flush_cnt_q;
      stall_f     = 1'b0;
      stall_d     = 1'b0;
      stall_e     = 1'b0;
      stall_m     = 1'b0;
      flush_d     = 1'b0;
      flush_e     = 1'b0;
      flush_w     = 1'b0;
      flush_inc   = 1'b0;

      freeze   = bus.mem_busy_i && (state_q != S_IDLE);
      lw_stall = (bus.ResultSrcE_i == 2'b01) && (bus.RdE_i != 5'd0) &&
                 ((bus.RdE_i == bus.Rs1D_i) || (bus.RdE_i == bus.Rs2D_i));

      if (state_q == S_IDLE) begin
         stall_f = 1'b1;
         stall_d = 1'b1;
         flush_e = 1'b1;
         if (bus.trigger_i) state_d = S_RUN;
      end else if (freeze) begin
         // Whole pipe holds; the pending redirect stays valid in E
         stall_f = 1'b1;
         stall_d = 1'b1;
         stall_e = 1'b1;
         stall_m = 1'b1;
         flush_w = 1'b1;
      end else if (state_q == S_RUN) begin
         if (bus.PCSrcE_i) begin
            flush_d   = 1'b1;
            flush_e   = 1'b1;
            flush_inc = 1'b1;
         end else if (lw_stall) begin
            stall_f = 1'b1;
            stall_d = 1'b1;
            flush_e = 1'b1;
         end else if (bus.halt_i) begin
            stall_f = 1'b1;
            flush_d = 1'b1;
            drain_d = DW'(DRAIN_CYC - 1);
            state_d = S_DRAIN;
         end
      end else begin
         stall_f = 1'b1;
         flush_d = 1'b1;
         if (drain_q == '0) state_d = S_IDLE;
         else               drain_d = drain_q - DW'(1);
      end

      if (stall_f && (state_q != S_IDLE) && (stall_cnt_q != '1))
         stall_cnt_d = stall_cnt_q + CNT_W'(1);
      if (flush_inc && (flush_cnt_q != '1))
         flush_cnt_d = flush_cnt_q + CNT_W'(1);
   end

   // Controller state registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_IDLE;
         drain_q     <= '0;
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         drain_q     <= drain_d;
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   // Output drive
   always_comb begin
      bus.StallF_o    = stall_f;
      bus.StallD_o    = stall_d;
      bus.StallE_o    = stall_e;
      bus.StallM_o    = stall_m;
      bus.FlushD_o    = flush_d;
      bus.FlushE_o    = flush_e;
      bus.FlushW_o    = flush_w;
      bus.state_o     = state_q;
      bus.stall_cnt_o = stall_cnt_q;
      bus.flush_cnt_o = flush_cnt_q;
   end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: a default-width instance plus a 4-bit
// counter instance fed the same inputs for the saturation check.
module tb_hazard_ctrl;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   total = 0;
   int   bad   = 0;

   hazard_ctrl_if #(.CNT_W(32)) ha ();
   hazard_ctrl_if #(.CNT_W(4))  hb ();

   hazard_ctrl #(.CNT_W(32), .DRAIN_CYC(3)) dut_a (.clk(clk), .rst(rst), .bus(ha));
   hazard_ctrl #(.CNT_W(4),  .DRAIN_CYC(3)) dut_b (.clk(clk), .rst(rst), .bus(hb));

   assign hb.trigger_i    = ha.trigger_i;
   assign hb.halt_i       = ha.halt_i;
   assign hb.mem_busy_i   = ha.mem_busy_i;
   assign hb.Rs1D_i       = ha.Rs1D_i;
   assign hb.Rs2D_i       = ha.Rs2D_i;
   assign hb.Rs1E_i       = ha.Rs1E_i;
   assign hb.Rs2E_i       = ha.Rs2E_i;
   assign hb.RdE_i        = ha.RdE_i;
   assign hb.RdM_i        = ha.RdM_i;
   assign hb.RdW_i        = ha.RdW_i;
   assign hb.ResultSrcE_i = ha.ResultSrcE_i;
   assign hb.RegWriteM_i  = ha.RegWriteM_i;
   assign hb.RegWriteW_i  = ha.RegWriteW_i;
   assign hb.PCSrcE_i     = ha.PCSrcE_i;

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clr_in();
      ha.trigger_i = 0; ha.halt_i = 0; ha.mem_busy_i = 0;
      ha.Rs1D_i = 0; ha.Rs2D_i = 0; ha.Rs1E_i = 0; ha.Rs2E_i = 0;
      ha.RdE_i = 0; ha.RdM_i = 0; ha.RdW_i = 0; ha.ResultSrcE_i = 0;
      ha.RegWriteM_i = 0; ha.RegWriteW_i = 0; ha.PCSrcE_i = 0;
   endtask

   initial begin
      clr_in();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      #1;
      // Reset / IDLE outputs
      chk("rst_state",  ha.state_o, 0);
      chk("rst_stallF", ha.StallF_o, 1);
      chk("rst_stallD", ha.StallD_o, 1);
      chk("rst_flushE", ha.FlushE_o, 1);
      chk("rst_flushD", ha.FlushD_o, 0);
      chk("rst_stallM", ha.StallM_o, 0);
      chk("rst_fwdA",   ha.ForwardAE_o, 0);
      chk("rst_scnt",   ha.stall_cnt_o, 0);
      chk("rst_fcnt",   ha.flush_cnt_o, 0);

      // Start
      ha.trigger_i = 1; tick(); ha.trigger_i = 0; #1;
      chk("run_state",  ha.state_o, 1);
      chk("run_stallF", ha.StallF_o, 0);
      chk("run_stallD", ha.StallD_o, 0);
      chk("run_flushE", ha.FlushE_o, 0);
      chk("run_flushD", ha.FlushD_o, 0);

      // Load-use
      ha.ResultSrcE_i = 2'b01; ha.RdE_i = 5; ha.Rs2D_i = 5; #1;
      chk("lw_stallF", ha.StallF_o, 1);
      chk("lw_stallD", ha.StallD_o, 1);
      chk("lw_flushE", ha.FlushE_o, 1);
      chk("lw_cnt0",   ha.stall_cnt_o, 0);
      tick();
      chk("lw_cnt1",   ha.stall_cnt_o, 1);
      ha.RdE_i = 0; #1;
      chk("lw_x0_stallF", ha.StallF_o, 0);
      chk("lw_x0_flushE", ha.FlushE_o, 0);
      tick();
      chk("lw_x0_cnt", ha.stall_cnt_o, 1);
      clr_in(); #1;

      // Forwarding
      ha.RdM_i = 7; ha.RdW_i = 7; ha.Rs1E_i = 7; ha.RegWriteM_i = 1; ha.RegWriteW_i = 1; #1;
      chk("fwdA_M", ha.ForwardAE_o, 2'b10);
      chk("fwdB_0", ha.ForwardBE_o, 2'b00);
      ha.RegWriteM_i = 0; #1;
      chk("fwdA_W", ha.ForwardAE_o, 2'b01);
      ha.RegWriteM_i = 1; ha.Rs1E_i = 0; #1;
      chk("fwdA_x0", ha.ForwardAE_o, 2'b00);
      ha.Rs2E_i = 7; #1;
      chk("fwdB_M", ha.ForwardBE_o, 2'b10);
      clr_in(); #1;

      // Redirect beats load-use
      ha.ResultSrcE_i = 2'b01; ha.RdE_i = 5; ha.Rs2D_i = 5; ha.PCSrcE_i = 1; #1;
      chk("br_flushD", ha.FlushD_o, 1);
      chk("br_flushE", ha.FlushE_o, 1);
      chk("br_stallF", ha.StallF_o, 0);
      tick();
      chk("br_fcnt", ha.flush_cnt_o, 1);
      chk("br_scnt", ha.stall_cnt_o, 1);
      clr_in(); #1;

      // Halt and drain: RUN(halt) then DRAIN x3 then IDLE
      ha.halt_i = 1; #1;
      chk("halt_stallF", ha.StallF_o, 1);
      chk("halt_flushD", ha.FlushD_o, 1);
      chk("halt_state",  ha.state_o, 1);
      tick(); ha.halt_i = 0; #1;
      chk("dr1_state",  ha.state_o, 2);
      chk("dr1_stallF", ha.StallF_o, 1);
      chk("dr1_flushD", ha.FlushD_o, 1);
      tick();
      chk("dr2_state", ha.state_o, 2);
      tick();
      chk("dr3_state", ha.state_o, 2);
      tick();
      chk("dr_idle",  ha.state_o, 0);
      chk("dr_scnt",  ha.stall_cnt_o, 5);

      // Drain with two frozen cycles -> five DRAIN cycles
      ha.trigger_i = 1; tick(); ha.trigger_i = 0;
      ha.halt_i = 1; tick(); ha.halt_i = 0; #1;
      chk("fz_d1", ha.state_o, 2);
      tick();
      ha.mem_busy_i = 1; #1;
      chk("fz_stallM", ha.StallM_o, 1);
      chk("fz_flushW", ha.FlushW_o, 1);
      chk("fz_stallE", ha.StallE_o, 1);
      chk("fz_flushD", ha.FlushD_o, 0);
      tick();
      chk("fz_d3_state",  ha.state_o, 2);
      chk("fz_d3_stallM", ha.StallM_o, 1);
      chk("fz_d3_flushW", ha.FlushW_o, 1);
      tick(); ha.mem_busy_i = 0; #1;
      chk("fz_d4_state",  ha.state_o, 2);
      chk("fz_d4_stallM", ha.StallM_o, 0);
      ha.PCSrcE_i = 1; #1;
      chk("fz_d4_noflushE", ha.FlushE_o, 0);
      tick(); ha.PCSrcE_i = 0; #1;
      chk("fz_d5_state", ha.state_o, 2);
      tick();
      chk("fz_idle", ha.state_o, 0);
      chk("fz_scnt", ha.stall_cnt_o, 11);
      chk("fz_fcnt", ha.flush_cnt_o, 1);

      // mem_busy ignored in IDLE
      ha.mem_busy_i = 1; #1;
      chk("idle_busy_stallM", ha.StallM_o, 0);
      chk("idle_busy_flushW", ha.FlushW_o, 0);
      tick();
      chk("idle_busy_scnt", ha.stall_cnt_o, 11);
      ha.mem_busy_i = 0;

      // Asynchronous reset mid-drain
      ha.trigger_i = 1; tick(); ha.trigger_i = 0;
      ha.halt_i = 1; tick(); ha.halt_i = 0; #1;
      chk("ar_pre", ha.state_o, 2);
      rst = 1'b1; #1;
      chk("ar_state", ha.state_o, 0);
      chk("ar_scnt",  ha.stall_cnt_o, 0);
      chk("ar_fcnt",  ha.flush_cnt_o, 0);
      chk("ar_b_scnt", hb.stall_cnt_o, 0);
      tick(); rst = 1'b0; #1;

      // Saturation: 20 load-use cycles
      ha.trigger_i = 1; tick(); ha.trigger_i = 0;
      ha.ResultSrcE_i = 2'b01; ha.RdE_i = 9; ha.Rs1D_i = 9;
      repeat (20) tick();
      chk("sat_b_scnt", hb.stall_cnt_o, 15);
      chk("sat_a_scnt", ha.stall_cnt_o, 20);
      chk("sat_b_state", hb.state_o, 1);
      clr_in();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
